// File: rtl/poly_dds_oscillator_pkg.sv
// Shared types and width helpers for the polyphonic DDS oscillator.
//   wave_t  : per-voice waveform select (sine, square, saw, reserved)
//   state_t : frame sequencer states (IDLE -> RUN -> OUT -> IDLE)
//   helpers : derived widths for voice index, sequencer index, product and mix accumulator
package poly_dds_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_SAW    = 2'd2,
    WAVE_RSVD   = 2'd3
  } wave_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Bits needed to select one of n voices.
  function automatic int unsigned voice_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Sequencer index runs 0..n inclusive, so one extra bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return voice_w(n) + 1;
  endfunction

  // Signed sample * unsigned volume, with a zero sign bit on the volume.
  function automatic int unsigned prod_w(input int unsigned sample_w, input int unsigned vol_w);
    return sample_w + vol_w + 1;
  endfunction

  // Sum of n full-scale contributions cannot overflow this width.
  function automatic int unsigned acc_w(input int unsigned sample_w, input int unsigned n);
    return sample_w + $clog2(n);
  endfunction

endpackage

// File: rtl/poly_dds_oscillator_if.sv
// Voice configuration bus for poly_dds_oscillator.
//   cfg_we        : write strobe, one cycle
//   cfg_voice     : target voice index
//   cfg_phase_inc : phase increment per frame
//   cfg_volume    : voice volume (gain = volume / 2^VOL_W)
//   cfg_wave      : 0 sine, 1 square, 2 saw, 3 reserved
//   cfg_gate      : 1 = note on
// master drives the bus (controller / bench), slave is the oscillator.
interface poly_dds_oscillator_if
  import poly_dds_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned PHASE_W    = 24,
  parameter int unsigned VOL_W      = 7
);

  localparam int unsigned VOICE_W = voice_w(NUM_VOICES);

  logic               cfg_we;
  logic [VOICE_W-1:0] cfg_voice;
  logic [PHASE_W-1:0] cfg_phase_inc;
  logic [VOL_W-1:0]   cfg_volume;
  logic [1:0]         cfg_wave;
  logic               cfg_gate;

  modport master (
    output cfg_we, cfg_voice, cfg_phase_inc, cfg_volume, cfg_wave, cfg_gate
  );

  modport slave (
    input cfg_we, cfg_voice, cfg_phase_inc, cfg_volume, cfg_wave, cfg_gate
  );

endinterface

// File: rtl/poly_dds_oscillator_wave_shaper.sv
// dds_wave_shaper: combinational waveform generation and volume scaling for one voice.
//   phase_top : top SAMPLE_W bits of the voice's pre-increment phase
//   wave      : waveform select
//   rom_data  : signed sine ROM sample for this voice's phase
//   volume    : unsigned gain numerator
//   gate      : 0 forces the contribution to zero
//   contrib   : (w * volume) >>> VOL_W, signed SAMPLE_W
module dds_wave_shaper
  import poly_dds_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 24,
  parameter int unsigned VOL_W    = 7
) (
  input  logic [SAMPLE_W-1:0]        phase_top,
  input  wave_t                      wave,
  input  logic signed [SAMPLE_W-1:0] rom_data,
  input  logic [VOL_W-1:0]           volume,
  input  logic                       gate,
  output logic signed [SAMPLE_W-1:0] contrib
);

  localparam int unsigned PROD_W = prod_w(SAMPLE_W, VOL_W);
  localparam logic signed [SAMPLE_W-1:0] FULL_SCALE = {1'b0, {(SAMPLE_W-1){1'b1}}};

  logic signed [SAMPLE_W-1:0] w;
  logic signed [PROD_W-1:0]   w_ext;
  logic signed [PROD_W-1:0]   vol_ext;
  logic signed [PROD_W-1:0]   prod;

  always_comb begin
    w = '0;
    unique case (wave)
      WAVE_SINE:   w = rom_data;
      WAVE_SQUARE: w = phase_top[SAMPLE_W-1] ? -FULL_SCALE : FULL_SCALE;
      // Offset-binary phase to two's complement: ramps from -FS to +FS.
      WAVE_SAW:    w = {~phase_top[SAMPLE_W-1], phase_top[SAMPLE_W-2:0]};
      default:     w = '0;
    endcase
  end

  assign w_ext   = PROD_W'(w);
  assign vol_ext = $signed(PROD_W'(volume));
  assign prod    = w_ext * vol_ext;
  // Result always fits SAMPLE_W since volume < 2^VOL_W.
  assign contrib = gate ? SAMPLE_W'(prod >>> VOL_W) : '0;

endmodule

// File: rtl/poly_dds_oscillator.sv
// poly_dds_oscillator: N-voice DDS oscillator sharing one synchronous sine ROM.
// On each sample_tick the sequencer walks all voices (one cycle each), issues
// the ROM address, advances gated phases, accumulates scaled contributions and
// emits one mixed signed sample.
//   clk, reset  : clock, synchronous active-high reset
//   sample_tick : one-cycle frame strobe
//   cfg         : voice configuration bus (slave)
//   rom_addr    : sine ROM address (phase top bits), holds outside RUN
//   rom_data    : ROM sample for the address presented on the previous cycle
//   mix_out     : mixed sample, mix_valid pulses when it updates
//   overrun     : pulses when sample_tick arrives while a frame is in progress
module poly_dds_oscillator
  import poly_dds_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned PHASE_W    = 24,
  parameter int unsigned ROM_ADDR_W = 12,
  parameter int unsigned SAMPLE_W   = 24,
  parameter int unsigned VOL_W      = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_tick,
  poly_dds_oscillator_if.slave       cfg,
  output logic [ROM_ADDR_W-1:0]      rom_addr,
  input  logic signed [SAMPLE_W-1:0] rom_data,
  output logic signed [SAMPLE_W-1:0] mix_out,
  output logic                       mix_valid,
  output logic                       overrun
);

  localparam int unsigned VW    = voice_w(NUM_VOICES);
  localparam int unsigned IW    = idx_w(NUM_VOICES);
  localparam int unsigned ACC_W = acc_w(SAMPLE_W, NUM_VOICES);
  localparam logic [IW-1:0] LAST = IW'(NUM_VOICES);

  state_t                     state;
  logic [IW-1:0]              idx;
  logic [VW-1:0]              vsel;
  logic [VW-1:0]              psel;

  logic [PHASE_W-1:0]         phase [NUM_VOICES];
  logic [PHASE_W-1:0]         inc   [NUM_VOICES];
  logic [VOL_W-1:0]           vol   [NUM_VOICES];
  wave_t                      wave  [NUM_VOICES];
  logic                       gate  [NUM_VOICES];

  logic [SAMPLE_W-1:0]        p_snap;
  logic signed [ACC_W-1:0]    acc;
  logic signed [SAMPLE_W-1:0] contrib;

  // vsel addresses the voice being issued, psel the voice whose ROM data
  // arrives this cycle (idx-1; wraps to NUM_VOICES-1 when idx == NUM_VOICES).
  assign vsel = idx[VW-1:0];
  assign psel = vsel - VW'(1);

  // p_snap carries the pre-increment phase one cycle to line up with rom_data;
  // wave/volume/gate are read live, so a config write already applied to a
  // voice (e.g. a gate clear) takes effect on that voice's contribution.
  dds_wave_shaper #(
    .SAMPLE_W (SAMPLE_W),
    .VOL_W    (VOL_W)
  ) u_shaper (
    .phase_top (p_snap),
    .wave      (wave[psel]),
    .rom_data  (rom_data),
    .volume    (vol[psel]),
    .gate      (gate[psel]),
    .contrib   (contrib)
  );

  always_ff @(posedge clk) begin
    mix_valid <= 1'b0;
    overrun   <= 1'b0;
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      acc      <= '0;
      p_snap   <= '0;
      rom_addr <= '0;
      mix_out  <= '0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        phase[v] <= '0;
        inc[v]   <= '0;
        vol[v]   <= '0;
        wave[v]  <= WAVE_SINE;
        gate[v]  <= 1'b0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (sample_tick) begin
            state <= RUN;
            idx   <= '0;
            acc   <= '0;
          end
        end
        RUN: begin
          if (sample_tick) overrun <= 1'b1;
          if (idx < LAST) begin
            rom_addr <= phase[vsel][PHASE_W-1 -: ROM_ADDR_W];
            p_snap   <= phase[vsel][PHASE_W-1 -: SAMPLE_W];
            if (gate[vsel]) phase[vsel] <= phase[vsel] + inc[vsel];
          end
          if (idx != '0) acc <= acc + ACC_W'(contrib);
          if (idx == LAST) state <= OUT;
          else             idx   <= idx + IW'(1);
        end
        OUT: begin
          if (sample_tick) overrun <= 1'b1;
          mix_out   <= SAMPLE_W'(acc >>> VW);
          mix_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Placed after the sequencer so a phase clear here overrides a
      // same-cycle phase increment of the same voice.
      if (cfg.cfg_we) begin
        inc[cfg.cfg_voice]  <= cfg.cfg_phase_inc;
        vol[cfg.cfg_voice]  <= cfg.cfg_volume;
        wave[cfg.cfg_voice] <= wave_t'(cfg.cfg_wave);
        gate[cfg.cfg_voice] <= cfg.cfg_gate;
        if (!gate[cfg.cfg_voice] || !cfg.cfg_gate) phase[cfg.cfg_voice] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_poly_dds_oscillator.sv
// Directed self-checking bench for poly_dds_oscillator (default parameters).
// The ROM model is a combinational table read of the DUT's registered
// rom_addr, so data for an address issued in one cycle is seen the next.
// Table: rom[a] = ({a,12'h000} ^ 0x800000) as signed, i.e. -2^23 + a*4096.
module tb_poly_dds_oscillator;
  import poly_dds_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               sample_tick;
  logic [11:0]        rom_addr;
  logic signed [23:0] rom_data;
  logic signed [23:0] mix_out;
  logic               mix_valid;
  logic               overrun;

  int tests = 0;
  int fails = 0;

  int          lat;
  int          n_valid;
  int          n_ovr;
  logic [23:0] mix_seen;
  logic [11:0] addr_seen [0:20];

  logic [23:0] saw_exp [5] = '{24'hF00000, 24'hF80000, 24'h000000, 24'h080000, 24'hF00000};
  logic [23:0] sin_exp [4] = '{24'hE80000, 24'hE80300, 24'hE80600, 24'hE80900};

  poly_dds_oscillator_if #(.NUM_VOICES(4), .PHASE_W(24), .VOL_W(7)) cfg_bus ();

  poly_dds_oscillator #(
    .NUM_VOICES (4),
    .PHASE_W    (24),
    .ROM_ADDR_W (12),
    .SAMPLE_W   (24),
    .VOL_W      (7)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .cfg         (cfg_bus),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] rom_model(input logic [11:0] a);
    return {a, 12'h000} ^ 24'h800000;
  endfunction

  assign rom_data = rom_model(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_load(input logic [1:0] v, input logic [23:0] inc, input logic [6:0] vol,
                          input logic [1:0] wave, input logic gate);
    cfg_bus.cfg_voice     = v;
    cfg_bus.cfg_phase_inc = inc;
    cfg_bus.cfg_volume    = vol;
    cfg_bus.cfg_wave      = wave;
    cfg_bus.cfg_gate      = gate;
  endtask

  task automatic cfg_write(input logic [1:0] v, input logic [23:0] inc, input logic [6:0] vol,
                           input logic [1:0] wave, input logic gate);
    @(negedge clk);
    cfg_load(v, inc, vol, wave, gate);
    cfg_bus.cfg_we = 1'b1;
    @(negedge clk);
    cfg_bus.cfg_we = 1'b0;
  endtask

  // Tick at negedge 0, then watch 20 negedges. Optional extra events at
  // negedge i: cfg_we strobe, second tick, or a one-cycle reset.
  task automatic run_frame(input int cfg_at, input int tick2_at, input int rst_at);
    lat     = -1;
    n_valid = 0;
    n_ovr   = 0;
    @(negedge clk);
    sample_tick = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      addr_seen[i] = rom_addr;
      if (mix_valid) begin
        n_valid++;
        if (lat < 0) begin
          lat      = i;
          mix_seen = mix_out;
        end
      end
      if (overrun) n_ovr++;
      sample_tick    = (i == tick2_at);
      cfg_bus.cfg_we = (i == cfg_at);
      reset          = (i == rst_at);
    end
    sample_tick    = 1'b0;
    cfg_bus.cfg_we = 1'b0;
    reset          = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    sample_tick    = 1'b0;
    cfg_bus.cfg_we = 1'b0;
    cfg_load(2'd0, 24'h0, 7'd0, 2'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("rst_mix_out", 32'(mix_out), 32'h0);
    chk("rst_mix_valid", 32'(mix_valid), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    reset = 1'b0;

    // Square on voice 0: phase (k-1)*0x100000, MSB set for frames 9..16 of each 16.
    cfg_write(2'd0, 24'h100000, 7'd127, 2'd1, 1'b1);
    for (int k = 1; k <= 25; k++) begin
      run_frame(-1, -1, -1);
      chk($sformatf("sq_lat%0d", k), 32'(lat), 32'd7);
      chk($sformatf("sq_mix%0d", k), 32'(mix_seen),
          (((k - 1) % 16) < 8) ? 32'h1FBFFF : 32'hE04000);
    end

    // Gate off mid-note (phase now 0x900000), then back on from phase 0.
    cfg_write(2'd0, 24'h100000, 7'd127, 2'd1, 1'b0);
    run_frame(-1, -1, -1);
    chk("gate_off_mix", 32'(mix_seen), 32'h0);
    chk("gate_off_addr", 32'(addr_seen[2]), 32'h0);
    cfg_write(2'd0, 24'h100000, 7'd127, 2'd1, 1'b1);
    run_frame(-1, -1, -1);
    chk("gate_on_lat", 32'(lat), 32'd7);
    chk("gate_on_mix", 32'(mix_seen), 32'h1FBFFF);

    // Gate-clear written on voice 0's own RUN cycle: clear beats the increment.
    cfg_load(2'd0, 24'h100000, 7'd127, 2'd1, 1'b0);
    run_frame(1, -1, -1);
    chk("coin_addr", 32'(addr_seen[2]), 32'h100);
    chk("coin_mix", 32'(mix_seen), 32'h0);
    run_frame(-1, -1, -1);
    chk("coin_next_addr", 32'(addr_seen[2]), 32'h0);
    chk("coin_next_mix", 32'(mix_seen), 32'h0);

    // Saw on voice 1.
    cfg_write(2'd1, 24'h400000, 7'd64, 2'd2, 1'b1);
    for (int k = 0; k < 5; k++) begin
      run_frame(-1, -1, -1);
      chk($sformatf("saw_lat%0d", k), 32'(lat), 32'd7);
      chk($sformatf("saw_mix%0d", k), 32'(mix_seen), 32'(saw_exp[k]));
    end
    cfg_write(2'd1, 24'h400000, 7'd64, 2'd2, 1'b0);

    // Sine on voice 2: address k on frame k; mix = ((rom[k]*96)>>>7)>>>2.
    cfg_write(2'd2, 24'h001000, 7'd96, 2'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      run_frame(-1, -1, -1);
      chk($sformatf("sin_addr%0d", k), 32'(addr_seen[4]), 32'(k));
      chk($sformatf("sin_lat%0d", k), 32'(lat), 32'd7);
      chk($sformatf("sin_mix%0d", k), 32'(mix_seen), 32'(sin_exp[k]));
    end

    // Second tick 3 cycles in: one overrun pulse, one frame, one phase step.
    run_frame(-1, 3, -1);
    chk("ovr_count", 32'(n_ovr), 32'd1);
    chk("ovr_valid_count", 32'(n_valid), 32'd1);
    chk("ovr_lat", 32'(lat), 32'd7);
    chk("ovr_mix", 32'(mix_seen), 32'hE80C00);
    run_frame(-1, -1, -1);
    chk("ovr_next_addr", 32'(addr_seen[4]), 32'd5);
    chk("ovr_next_mix", 32'(mix_seen), 32'hE80F00);

    // Reset mid-frame: no mix_valid, outputs cleared, next frame silent.
    run_frame(-1, -1, 3);
    chk("rst_mid_valid_count", 32'(n_valid), 32'd0);
    chk("rst_mid_rom_addr", 32'(rom_addr), 32'h0);
    chk("rst_mid_mix_out", 32'(mix_out), 32'h0);
    chk("rst_mid_mix_valid", 32'(mix_valid), 32'h0);
    chk("rst_mid_overrun", 32'(overrun), 32'h0);
    run_frame(-1, -1, -1);
    chk("post_rst_lat", 32'(lat), 32'd7);
    chk("post_rst_mix", 32'(mix_seen), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/poly_dds_oscillator.md
Name: poly_dds_oscillator

Overview:
- N-voice direct-digital-synthesis oscillator for the MIDI synth.
- Each voice has a fractional phase accumulator, a selectable waveform, per-voice volume and a gate.
- The voices share one external synchronous sine ROM, time-multiplexed per audio frame.
- On each sample_tick it walks all voices, scales and sums them, and emits one mixed signed sample to the audio output path (codec serializer).

Parameters:
- NUM_VOICES, 4, number of voices; power of two, 2..16
- PHASE_W, 24, phase accumulator width; must be >= SAMPLE_W and >= ROM_ADDR_W
- ROM_ADDR_W, 12, sine ROM address width; address = phase top bits
- SAMPLE_W, 24, signed sample width of ROM data and mix output
- VOL_W, 7, volume width; gain = volume / 2^VOL_W

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- sample_tick  in  1  one-cycle frame strobe (e.g. 48 kHz)
- cfg_we  in  1  voice config write strobe
- cfg_voice  in  $clog2(NUM_VOICES)  voice index for the write
- cfg_phase_inc  in  PHASE_W  phase increment per frame (frequency)
- cfg_volume  in  VOL_W  voice volume
- cfg_wave  in  2  0 sine, 1 square, 2 saw, 3 reserved (outputs 0)
- cfg_gate  in  1  1 = note on
- rom_addr  out  ROM_ADDR_W  sine ROM address
- rom_data  in  SAMPLE_W  signed ROM output; 1-cycle registered latency
- mix_out  out  SAMPLE_W  signed mixed sample
- mix_valid  out  1  one-cycle pulse when mix_out updates
- overrun  out  1  one-cycle pulse when a sample_tick arrives while busy

Behaviour:
- Reset values:
  - All phase, inc, volume and gate registers = 0; wave = sine.
  - rom_addr, mix_out, mix_valid and overrun = 0; FSM = IDLE.
  - Reset mid-frame aborts the frame and emits no mix_valid.
- FSM states: IDLE -> RUN -> OUT -> IDLE.
  - IDLE: sample_tick=1 -> RUN with idx=0 and accumulator cleared.
  - RUN: runs idx = 0..NUM_VOICES, one cycle each.
    - For idx < N: rom_addr <= phase[idx][PHASE_W-1 -: ROM_ADDR_W] (registered), and phase[idx] <= phase[idx] + inc[idx] (mod 2^PHASE_W) if gate=1.
    - For idx >= 1: the contribution of voice idx-1 is added to the accumulator, using rom_data for sine.
    - After idx = N -> OUT.
  - OUT: mix_out <= acc >>> $clog2(NUM_VOICES) (arithmetic shift), mix_valid <= 1 for one cycle, then -> IDLE.
- Latency: mix_valid is high exactly NUM_VOICES+3 cycles after the cycle in which sample_tick was sampled (7 for the defaults).
- Each frame uses the phase value from before its increment, so the first frame after gate-on uses phase 0.
- Waveform value w, signed SAMPLE_W, computed from the pre-increment phase p:
  - sine: rom_data
  - square: p MSB = 0 -> +(2^(SAMPLE_W-1)-1); otherwise -(2^(SAMPLE_W-1)-1)
  - saw: p[PHASE_W-1 -: SAMPLE_W] with MSB inverted, read as signed
  - reserved (wave 3): 0
- Voice contribution = (w * volume) >>> VOL_W.
  - Product width is SAMPLE_W+VOL_W+1, signed; volume is treated as unsigned.
  - gate=0 -> contribution 0.
- Accumulator width is SAMPLE_W + $clog2(NUM_VOICES), so the sum never overflows.
- Config writes:
  - Applied the cycle after cfg_we.
  - A write to voice v while gate=0 also sets phase[v] = 0.
  - A write with cfg_gate=0 clears phase[v].
  - A write that coincides with voice v's RUN cycle: the config registers take the written values, the phase uses the old inc, and a gate-clear overrides the phase increment.
- Busy rule: sample_tick in RUN or OUT is dropped and pulses overrun for one cycle.
- Outside RUN, rom_addr holds its last value.

Decomposition:
- Package poly_dds_pkg holds:
  - wave_t enum (WAVE_SINE=0, WAVE_SQUARE=1, WAVE_SAW=2, WAVE_RSVD=3)
  - state_t enum (IDLE, RUN, OUT)
  - width helper functions
- Sub-module dds_wave_shaper (combinational): takes phase, wave, rom_data, volume and gate, and returns the scaled contribution. The top level holds the FSM, the register file and the mix accumulator.

Test Plan:
- Bench provides a 1-cycle-latency sine ROM model.
- Square wave: reset; voice0 set to square, inc=0x100000, vol=127, gate=1; other voices off.
  - Ticks 1-8 -> mix_out=0x1FBFFF.
  - Ticks 9-16 -> 0xE04000.
  - Each mix_valid arrives exactly 7 cycles after its tick.
- Saw wave: voice1 set to saw, inc=0x400000, vol=64.
  - Successive mix_out = 0xF00000, 0xF80000, 0x000000, 0x080000, then 0xF00000 again (wrap).
- Sine voice: voice2 set to sine, inc=0x001000.
  - Observed rom_addr for voice2 increments by 1 per frame.
  - Each mix_out equals (rom[k]*vol >>> 7) >>> 2.
- Gate and config writes: gate-off write mid-note -> contribution 0 next frame. Gate back on -> first frame uses phase 0 (square gives +0x1FBFFF at vol=127). Also a config write on the same cycle as that voice's RUN cycle -> gate-clear wins.
- Overrun: a second sample_tick 3 cycles after the first -> overrun pulses once and exactly one mix_valid is produced.
- Reset mid-operation: assert reset during RUN -> no mix_valid, all outputs 0, and the next tick produces a clean frame with all voices silent (mix_out=0).
